pipe_perf_monitor: RTL and testbench

PIPE_PERF_MONITOR -- requirements
Module: pipe_perf_monitor

---
 rtl/pipe_perf_pkg.sv | 22 ++
 rtl/perf_sat_counter.sv | 31 +++
 rtl/pipe_perf_monitor.sv | 151 +++++++++++++++
 tb/tb_pipe_perf_monitor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_perf_pkg.sv
// Shared state encoding, read-select codes and default sizing for the pipeline
// performance monitor.
package pipe_perf_pkg;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_CYCLE_LIMIT = 30;
  localparam int unsigned DEF_HANG_N      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_CYCLES  = 2'd0,
    SEL_STALLS  = 2'd1,
    SEL_FLUSHES = 2'd2,
    SEL_RETIRED = 2'd3
  } rd_sel_e;

endpackage

// File: rtl/perf_sat_counter.sv
// Event counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
module perf_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Counts cycles, stalls, flushes and retirements of a pipelined CPU, stops after a
// fixed run length or when the PC sits still, and serves one-cycle-latency reads.
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned CYCLE_LIMIT = DEF_CYCLE_LIMIT,
  parameter int unsigned HANG_N      = DEF_HANG_N
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [31:0]      pc_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_sel_i,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             running_o,
  output logic             done_o,
  output logic             hang_o
);

  localparam int unsigned HANG_W = $clog2(HANG_N + 1);

  state_e            state_q, state_d;
  logic [HANG_W-1:0] hangCnt_q, hangCnt_d;
  logic [31:0]       pcPrev_q, pcPrev_d;
  logic              hangFlag_q, hangFlag_d;
  logic              rdValid_q;
  logic [CNT_W-1:0]  rdData_q, rdData_d;

  logic              counting;
  logic              hangHit;
  logic              limitHit;
  logic [CNT_W-1:0]  cycleCnt, stallCnt, flushCnt, retireCnt;
  logic [CNT_W-1:0]  cycleNext;

  assign counting = (state_q == ST_RUN) && start_i;

  perf_sat_counter #(.W(CNT_W)) uCycleCnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (counting),
    .cnt_o (cycleCnt)
  );

  perf_sat_counter #(.W(CNT_W)) uStallCnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (counting && stall_i),
    .cnt_o (stallCnt)
  );

  perf_sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (counting && flush_i),
    .cnt_o (flushCnt)
  );

  perf_sat_counter #(.W(CNT_W)) uRetireCnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (counting && retire_i),
    .cnt_o (retireCnt)
  );

  // The limit compare is done wide so a narrow, saturated counter can never alias CYCLE_LIMIT.
  assign cycleNext = (cycleCnt == '1) ? cycleCnt : cycleCnt + CNT_W'(1);
  assign limitHit  = counting && (64'(cycleNext) == 64'(CYCLE_LIMIT));

  always_comb begin
    hangCnt_d = hangCnt_q;
    pcPrev_d  = pcPrev_q;
    hangHit   = 1'b0;
    if (counting) begin
      pcPrev_d = pc_i;
      if (!stall_i && (pc_i == pcPrev_q)) begin
        hangCnt_d = hangCnt_q + HANG_W'(1);
        hangHit   = (hangCnt_d == HANG_W'(HANG_N));
      end else begin
        hangCnt_d = '0;
      end
    end
  end

  // A hang wins the flag even when the run limit lands on the same edge.
  always_comb begin
    state_d    = state_q;
    hangFlag_d = hangFlag_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hangHit || limitHit) begin
          state_d    = ST_DONE;
          hangFlag_d = hangHit;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rdData_d = '0;
    if (rd_req_i) begin
      case (rd_sel_i)
        SEL_CYCLES:  rdData_d = cycleCnt;
        SEL_STALLS:  rdData_d = stallCnt;
        SEL_FLUSHES: rdData_d = flushCnt;
        SEL_RETIRED: rdData_d = retireCnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      hangCnt_q  <= '0;
      pcPrev_q   <= '0;
      hangFlag_q <= 1'b0;
      rdValid_q  <= 1'b0;
      rdData_q   <= '0;
    end else begin
      state_q    <= state_d;
      hangCnt_q  <= hangCnt_d;
      pcPrev_q   <= pcPrev_d;
      hangFlag_q <= hangFlag_d;
      rdValid_q  <= rd_req_i;
      rdData_q   <= rdData_d;
    end
  end

  assign rd_valid_o = rdValid_q;
  assign rd_data_o  = rdData_q;
  assign running_o  = (state_q == ST_RUN);
  assign done_o     = (state_q == ST_DONE);
  assign hang_o     = hangFlag_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed scenarios with fixed expectations and a
// randomized run compared every cycle against a behavioural model.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stall, flush, retire, rdReq;
  logic [31:0] pc;
  logic [1:0]  rdSel;
  logic        rdValid, running, done, hang;
  logic [31:0] rdData;

  logic        nRst, nStart, nRetire, nRdReq;
  logic [31:0] nPc;
  logic [1:0]  nRdSel;
  logic        nRdValid, nRunning, nDone, nHang;
  logic [3:0]  nRdData;

  int checks   = 0;
  int failures = 0;

  pipe_perf_monitor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .retire_i(retire), .pc_i(pc), .rd_req_i(rdReq), .rd_sel_i(rdSel),
    .rd_valid_o(rdValid), .rd_data_o(rdData), .running_o(running), .done_o(done),
    .hang_o(hang)
  );

  pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(30), .HANG_N(8)) dutNarrow (
    .clk_i(clk), .rst_i(nRst), .start_i(nStart), .stall_i(1'b0), .flush_i(1'b0),
    .retire_i(nRetire), .pc_i(nPc), .rd_req_i(nRdReq), .rd_sel_i(nRdSel),
    .rd_valid_o(nRdValid), .rd_data_o(nRdData), .running_o(nRunning), .done_o(nDone),
    .hang_o(nHang)
  );

  // Behavioural model of the main instance: 0 idle, 1 run, 2 done.
  int          mState;
  logic [31:0] mCnt [4];
  logic [31:0] mPrevPc;
  int          mHang;
  logic        mHangFlag, mRdValid;
  logic [31:0] mRdData;

  function automatic logic [31:0] bump(input logic [31:0] c, input logic en);
    return (en && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
  endfunction

  task automatic model_step();
    if (rst) begin
      mState = 0; mPrevPc = '0; mHang = 0; mHangFlag = 1'b0;
      mRdValid = 1'b0; mRdData = '0;
      for (int i = 0; i < 4; i++) mCnt[i] = '0;
    end else begin
      mRdValid = rdReq;
      mRdData  = rdReq ? mCnt[rdSel] : '0;
      if (mState == 0) begin
        if (start) mState = 1;
      end else if (mState == 1 && start) begin
        mCnt[0] = bump(mCnt[0], 1'b1);
        mCnt[1] = bump(mCnt[1], stall);
        mCnt[2] = bump(mCnt[2], flush);
        mCnt[3] = bump(mCnt[3], retire);
        mHang   = (!stall && pc == mPrevPc) ? mHang + 1 : 0;
        mPrevPc = pc;
        if (mHang == 8 || mCnt[0] == 32'd30) begin
          mHangFlag = (mHang == 8);
          mState    = 2;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; retire = 1'b0;
    rdReq = 1'b0; rdSel = 2'd0; pc = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; rdReq = 1'b1; rdSel = 2'd0;
    stall = 1'b0; flush = 1'b0; retire = 1'b0; pc = '0;
    step();
    checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", rdValid); end
    checks++; if (rdData !== 32'd0) begin failures++; $display("[TB] FAIL reset_data got=%0d exp=0", rdData); end
    checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL reset_running got=%b exp=0", running); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (hang !== 1'b0) begin failures++; $display("[TB] FAIL reset_hang got=%b exp=0", hang); end
    rst = 1'b0; start = 1'b0; rdReq = 1'b1; rdSel = 2'd0;
    step();
    rdReq = 1'b0;
    checks++; if (rdValid !== 1'b1 || rdData !== 32'd0 || running !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_idle_read got v=%b d=%0d r=%b exp v=1 d=0 r=0", rdValid, rdData, running);
    end
  endtask

  task automatic test_limit();
    do_reset();
    start = 1'b1; pc = '0;
    step();
    for (int i = 1; i <= 30; i++) begin
      pc = pc + 32'd4;
      step();
      checks++; if (done !== (i == 30) || running !== (i < 30)) begin
        failures++; $display("[TB] FAIL limit_state edge=%0d got done=%b run=%b exp done=%b", i, done, running, i == 30);
      end
    end
    rdReq = 1'b1; rdSel = 2'd0;
    step();
    rdReq = 1'b0;
    checks++; if (rdValid !== 1'b1 || rdData !== 32'd30 || hang !== 1'b0) begin
      failures++; $display("[TB] FAIL limit_read got v=%b d=%0d h=%b exp v=1 d=30 h=0", rdValid, rdData, hang);
    end
    step();
    checks++; if (rdValid !== 1'b0 || rdData !== 32'd0) begin
      failures++; $display("[TB] FAIL limit_read_drop got v=%b d=%0d exp v=0 d=0", rdValid, rdData);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] expVals [4];
    expVals[0] = 32'd12; expVals[1] = 32'd3; expVals[2] = 32'd3; expVals[3] = 32'd0;
    do_reset();
    start = 1'b1; pc = 32'h100;
    step();
    for (int i = 0; i < 12; i++) begin
      stall = (i >= 3 && i <= 5);
      flush = stall;
      if (!stall) pc = pc + 32'd4;
      step();
    end
    stall = 1'b0; flush = 1'b0; start = 1'b0;
    // Back-to-back reads of every counter, each answered in order.
    for (int s = 1; s <= 4; s++) begin
      rdReq = 1'b1; rdSel = 2'(s % 4);
      step();
      checks++; if (rdValid !== 1'b1 || rdData !== expVals[s % 4]) begin
        failures++; $display("[TB] FAIL stall_flush_read sel=%0d got v=%b d=%0d exp v=1 d=%0d", s % 4, rdValid, rdData, expVals[s % 4]);
      end
    end
    rdReq = 1'b0;
    step();
    checks++; if (rdValid !== 1'b0 || rdData !== 32'd0 || running !== 1'b1) begin
      failures++; $display("[TB] FAIL back_to_back_end got v=%b d=%0d r=%b exp v=0 d=0 r=1", rdValid, rdData, running);
    end
  endtask

  task automatic test_hang();
    logic [31:0] expVals [4];
    expVals[0] = 32'd9; expVals[1] = 32'd1; expVals[2] = 32'd0; expVals[3] = 32'd0;
    do_reset();
    start = 1'b1; pc = 32'h10;
    step();
    stall = 1'b1;
    step();
    stall = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (done !== (i == 8) || hang !== (i == 8)) begin
        failures++; $display("[TB] FAIL hang_edge edge=%0d got done=%b hang=%b exp=%b", i, done, hang, i == 8);
      end
    end
    for (int i = 0; i < 5; i++) begin
      stall = 1'b1; flush = 1'b1; retire = 1'b1; pc = pc + 32'd4;
      step();
    end
    stall = 1'b0; flush = 1'b0; retire = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rdReq = 1'b1; rdSel = 2'(s);
      step();
      checks++; if (rdValid !== 1'b1 || rdData !== expVals[s] || done !== 1'b1 || hang !== 1'b1) begin
        failures++; $display("[TB] FAIL hang_frozen sel=%0d got d=%0d done=%b hang=%b exp d=%0d done=1 hang=1", s, rdData, done, hang, expVals[s]);
      end
    end
    rdReq = 1'b0; rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    checks++; if (done !== 1'b0 || hang !== 1'b0 || running !== 1'b0) begin
      failures++; $display("[TB] FAIL done_reset got done=%b hang=%b run=%b exp all 0", done, hang, running);
    end
  endtask

  task automatic test_pause();
    do_reset();
    start = 1'b1; pc = '0;
    step();
    for (int i = 0; i < 5; i++) begin pc = pc + 32'd4; step(); end
    start = 1'b0; retire = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = pc + 32'd4;
      step();
      checks++; if (running !== 1'b1 || done !== 1'b0) begin
        failures++; $display("[TB] FAIL pause_running gap=%0d got run=%b done=%b exp run=1 done=0", i, running, done);
      end
    end
    retire = 1'b0; rdReq = 1'b1; rdSel = 2'd0;
    step();
    checks++; if (rdValid !== 1'b1 || rdData !== 32'd5) begin
      failures++; $display("[TB] FAIL pause_cycles got v=%b d=%0d exp v=1 d=5", rdValid, rdData);
    end
    rdSel = 2'd3;
    step();
    rdReq = 1'b0;
    checks++; if (rdValid !== 1'b1 || rdData !== 32'd0) begin
      failures++; $display("[TB] FAIL pause_retire got v=%b d=%0d exp v=1 d=0", rdValid, rdData);
    end
  endtask

  task automatic test_read_timing_and_reset();
    do_reset();
    start = 1'b1; pc = '0;
    step();
    for (int i = 0; i < 12; i++) begin pc = pc + 32'd4; step(); end
    rdReq = 1'b1; rdSel = 2'd0; pc = pc + 32'd4;
    step();
    checks++; if (rdValid !== 1'b1 || rdData !== 32'd12) begin
      failures++; $display("[TB] FAIL read_12_13 got v=%b d=%0d exp v=1 d=12", rdValid, rdData);
    end
    rdReq = 1'b0; pc = pc + 32'd4;
    step();
    checks++; if (rdValid !== 1'b0 || rdData !== 32'd0) begin
      failures++; $display("[TB] FAIL read_one_cycle got v=%b d=%0d exp v=0 d=0", rdValid, rdData);
    end
    rst = 1'b1; start = 1'b1; rdReq = 1'b1;
    step();
    checks++; if ({rdValid, running, done, hang} !== 4'b0000 || rdData !== 32'd0) begin
      failures++; $display("[TB] FAIL midrun_reset got v=%b d=%0d r=%b dn=%b h=%b exp all 0", rdValid, rdData, running, done, hang);
    end
    rst = 1'b0; start = 1'b0; rdReq = 1'b0;
    step();
    checks++; if (rdValid !== 1'b0 || running !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_read_dropped got v=%b r=%b exp v=0 r=0", rdValid, running);
    end
    start = 1'b1;
    step();
    start = 1'b0; rdReq = 1'b1; rdSel = 2'd0;
    step();
    rdReq = 1'b0;
    checks++; if (rdValid !== 1'b1 || rdData !== 32'd0 || running !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_cleared_count got v=%b d=%0d r=%b exp v=1 d=0 r=1", rdValid, rdData, running);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      start  = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 4) == 0);
      retire = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 9) >= 7) pc = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      rdReq  = ($urandom_range(0, 2) == 0);
      rdSel  = 2'($urandom_range(0, 3));
      step();
      checks++;
      if ({rdValid, running, done, hang} !== {mRdValid, mState == 1, mState == 2, mHangFlag} || rdData !== mRdData) begin
        failures++;
        $display("[TB] FAIL random_model i=%0d got v=%b d=%0d r=%b dn=%b h=%b exp v=%b d=%0d r=%b dn=%b h=%b",
                 i, rdValid, rdData, running, done, hang, mRdValid, mRdData, mState == 1, mState == 2, mHangFlag);
      end
    end
    rst = 1'b0; rdReq = 1'b0; start = 1'b0;
  endtask

  task automatic test_narrow();
    nRst = 1'b1;
    step();
    nRst = 1'b0; nStart = 1'b1; nRetire = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin nPc = nPc + 32'd4; step(); end
    nStart = 1'b0; nRdReq = 1'b1; nRdSel = 2'd3;
    step();
    checks++; if (nRdValid !== 1'b1 || nRdData !== 4'd15) begin
      failures++; $display("[TB] FAIL narrow_retire_sat got v=%b d=%0d exp v=1 d=15", nRdValid, nRdData);
    end
    nRdSel = 2'd0;
    step();
    checks++; if (nRdData !== 4'd15 || nDone !== 1'b0 || nRunning !== 1'b1) begin
      failures++; $display("[TB] FAIL narrow_cycle_sat got d=%0d done=%b run=%b exp d=15 done=0 run=1", nRdData, nDone, nRunning);
    end
    nRdReq = 1'b0; nStart = 1'b1;
    for (int i = 0; i < 3; i++) begin nPc = nPc + 32'd4; step(); end
    nRst = 1'b1; nRdReq = 1'b1;
    step();
    checks++; if ({nRdValid, nRunning, nDone, nHang} !== 4'b0000 || nRdData !== 4'd0) begin
      failures++; $display("[TB] FAIL narrow_reset got v=%b d=%0d r=%b dn=%b h=%b exp all 0", nRdValid, nRdData, nRunning, nDone, nHang);
    end
    nRst = 1'b0; nStart = 1'b0; nRdReq = 1'b0;
    step();
    checks++; if (nRunning !== 1'b0 || nRdValid !== 1'b0) begin
      failures++; $display("[TB] FAIL narrow_idle got r=%b v=%b exp r=0 v=0", nRunning, nRdValid);
    end
  endtask

  initial begin
    nRst = 1'b1; nStart = 1'b0; nRetire = 1'b0; nRdReq = 1'b0; nRdSel = 2'd0; nPc = 32'h40;
    do_reset();
    test_reset();
    test_limit();
    test_stall_flush();
    test_hang();
    test_pause();
    test_read_timing_and_reset();
    test_random();
    test_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
